hex_scan_ctrl: RTL and testbench



---
 rtl/hex_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_hex_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - time-shared hex-to-7-segment scan controller with shadowed commit
// One decoder serves all digits; the board outputs only change on the single COMMIT cycle.

module BCD_7Seg (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    // Active-low segments, bit order gfedcba.
    always_comb begin
        seg_o = 7'h7F;
        case (bcd_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end
endmodule

module hex_scan_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  RST_N,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic                  BLANK_LZ,
    input  logic                  LOAD,
    output logic                  READY,
    output logic                  DONE,
    output logic [7*DIGITS-1:0]   HEX_BUS
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_COMMIT
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 seen_nz_q;
    logic                 blank_q;
    logic                 done_q;
    logic [3:0]           nib_q    [DIGITS];
    logic [6:0]           shadow_q [DIGITS];
    logic [7*DIGITS-1:0]  hex_q;

    logic [3:0] cur_nib;
    logic [6:0] dec_seg;
    logic [6:0] seg_d;

    assign cur_nib = nib_q[idx_q];

    BCD_7Seg u_dec (
        .bcd_i (cur_nib),
        .seg_o (dec_seg)
    );

    // Leading zeros go dark until the first nonzero digit; digit 0 always shows.
    always_comb begin
        seg_d = dec_seg;
        if (blank_q && !seen_nz_q && (cur_nib == 4'h0) && (idx_q != '0)) begin
            seg_d = 7'h7F;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            idx_q     <= IDX_LAST;
            seen_nz_q <= 1'b0;
            blank_q   <= 1'b0;
            done_q    <= 1'b0;
            hex_q     <= '1;
            for (int i = 0; i < DIGITS; i++) begin
                nib_q[i]    <= 4'h0;
                shadow_q[i] <= 7'h7F;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (LOAD) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            nib_q[i] <= VALUE[4*i +: 4];
                        end
                        blank_q   <= BLANK_LZ;
                        idx_q     <= IDX_LAST;
                        seen_nz_q <= 1'b0;
                        state_q   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    shadow_q[idx_q] <= seg_d;
                    seen_nz_q       <= seen_nz_q | (cur_nib != 4'h0);
                    if (idx_q == '0) begin
                        state_q <= S_COMMIT;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                S_COMMIT: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        hex_q[7*i +: 7] <= shadow_q[i];
                    end
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign READY   = (state_q == S_IDLE);
    assign DONE    = done_q;
    assign HEX_BUS = hex_q;
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb/tb_hex_scan_ctrl.sv - directed self-checking bench for hex_scan_ctrl (DIGITS=4)
module tb_hex_scan_ctrl;
    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        blank_lz;
    logic        load;
    logic        ready;
    logic        done;
    logic [27:0] hex_bus;

    int total;
    int bad;

    localparam logic [27:0] BLANK_ALL = 28'hFFFFFFF;
    localparam logic [27:0] HEX_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] HEX_1111  = {7'h79, 7'h79, 7'h79, 7'h79};
    localparam logic [27:0] HEX_FFFF  = {7'h0E, 7'h0E, 7'h0E, 7'h0E};
    localparam logic [27:0] HEX_8888  = 28'h0000000;

    hex_scan_ctrl #(.DIGITS(4)) dut (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .VALUE    (value),
        .BLANK_LZ (blank_lz),
        .LOAD     (load),
        .READY    (ready),
        .DONE     (done),
        .HEX_BUS  (hex_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse LOAD for one edge, then wait (bounded) for DONE; lat=-1 on timeout.
    task automatic load_and_wait(input logic [15:0] v, input logic b, output int lat);
        value    = v;
        blank_lz = b;
        load     = 1'b1;
        tick();
        load = 1'b0;
        lat  = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #23;
        rst_n = 1'b0;
        #1;
        total++;
        if (hex_bus !== BLANK_ALL) begin bad++; $display("FAIL reset_hex: got %h want %h", hex_bus, BLANK_ALL); end
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        value    = 16'h1234;
        blank_lz = 1'b0;
        load     = 1'b1;
        tick();
        load = 1'b0;
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL basic_ready_busy: got %b want 0", ready); end
        value = 16'hFFFF;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (hex_bus !== BLANK_ALL || done !== 1'b0) begin
                bad++;
                $display("FAIL basic_early_%0d: got hex=%h done=%b want hex=%h done=0", k, hex_bus, done, BLANK_ALL);
            end
        end
        tick();
        total++;
        if (hex_bus !== HEX_1234) begin bad++; $display("FAIL basic_hex: got %h want %h", hex_bus, HEX_1234); end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", done); end
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL basic_ready_done: got %b want 1", ready); end
        tick();
        total++;
        if (done !== 1'b0 || hex_bus !== HEX_1234) begin
            bad++;
            $display("FAIL basic_after: got done=%b hex=%h want done=0 hex=%h", done, hex_bus, HEX_1234);
        end
    endtask

    task automatic test_blanking();
        int lat;
        logic [15:0] vals [3];
        logic [27:0] exps [3];
        vals[0] = 16'h0005; exps[0] = {7'h7F, 7'h7F, 7'h7F, 7'h12};
        vals[1] = 16'h0000; exps[1] = {7'h7F, 7'h7F, 7'h7F, 7'h40};
        vals[2] = 16'h0A0F; exps[2] = {7'h7F, 7'h08, 7'h40, 7'h0E};
        for (int k = 0; k < 3; k++) begin
            load_and_wait(vals[k], 1'b1, lat);
            total++;
            if (lat !== 5) begin bad++; $display("FAIL blank_lat_%0d: got %0d want 5", k, lat); end
            total++;
            if (hex_bus !== exps[k]) begin bad++; $display("FAIL blank_hex_%0d: got %h want %h", k, hex_bus, exps[k]); end
            tick();
        end
    endtask

    task automatic test_ignore_busy();
        int dones;
        value    = 16'h1111;
        blank_lz = 1'b0;
        load     = 1'b1;
        tick();
        load = 1'b0;
        tick();
        value = 16'h2222;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        dones = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
        total++;
        if (hex_bus !== HEX_1111) begin bad++; $display("FAIL ignore_hex: got %h want %h", hex_bus, HEX_1111); end
    endtask

    task automatic test_back_to_back();
        logic [27:0] model_hex;
        logic        exp_done;
        int          acc;
        model_hex = HEX_1111;
        acc       = 0;
        value     = 16'hFFFF;
        blank_lz  = 1'b0;
        load      = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (c % 6 == 0) begin
                acc++;
                value = (acc % 2 == 1) ? 16'h8888 : 16'hFFFF;
            end
            exp_done = (c % 6 == 5);
            if (exp_done) model_hex = ((c / 6) % 2 == 0) ? HEX_FFFF : HEX_8888;
            if (c == 23) load = 1'b0;
            total++;
            if (done !== exp_done) begin bad++; $display("FAIL b2b_done_c%0d: got %b want %b", c, done, exp_done); end
            total++;
            if (hex_bus !== model_hex) begin bad++; $display("FAIL b2b_hex_c%0d: got %h want %h", c, hex_bus, model_hex); end
        end
        for (int k = 0; k < 3; k++) tick();
        total++;
        if (ready !== 1'b1 || hex_bus !== HEX_8888) begin
            bad++;
            $display("FAIL b2b_end: got ready=%b hex=%h want ready=1 hex=%h", ready, hex_bus, HEX_8888);
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        int dones;
        load_and_wait(16'h1234, 1'b0, lat);
        total++;
        if (hex_bus !== HEX_1234) begin bad++; $display("FAIL mid_pre_hex: got %h want %h", hex_bus, HEX_1234); end
        tick();
        value = 16'h9999;
        load  = 1'b1;
        tick();
        load = 1'b0;
        tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (hex_bus !== BLANK_ALL) begin bad++; $display("FAIL mid_rst_hex: got %h want %h", hex_bus, BLANK_ALL); end
        total++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_ctrl: got ready=%b done=%b want ready=1 done=0", ready, done);
        end
        tick();
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones !== 0 || hex_bus !== BLANK_ALL || ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_post: got dones=%0d hex=%h ready=%b want dones=0 hex=%h ready=1", dones, hex_bus, ready, BLANK_ALL);
        end
        load_and_wait(16'h1234, 1'b0, lat);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL mid_next_lat: got %0d want 5", lat); end
        total++;
        if (hex_bus !== HEX_1234) begin bad++; $display("FAIL mid_next_hex: got %h want %h", hex_bus, HEX_1234); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b1;
        value    = 16'h0;
        blank_lz = 1'b0;
        load     = 1'b0;
        test_reset();
        test_basic();
        tick();
        test_blanking();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
